fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads one 2-byte instruction per cycle at pc into a
// 2-entry in-order buffer that feeds decode; branch redirects flush the buffer.
module fetch_stage #(
    parameter int                    data_width = 8,
    parameter int                    addr_width = 16,
    parameter logic [addr_width-1:0] reset_pc   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [addr_width-1:0]     mem_address,
    input  logic [data_width-1:0]     mem_data_high,
    input  logic [data_width-1:0]     mem_data_low,
    input  logic                      fetch_en,
    input  logic                      branch_taken,
    input  logic [addr_width-1:0]     branch_target,
    input  logic                      dec_ready,
    output logic                      dec_valid,
    output logic [2*data_width-1:0]   dec_instr,
    output logic [addr_width-1:0]     dec_pc,
    output logic [1:0]                fetch_level
);

    localparam int iw = 2 * data_width;

    logic [addr_width-1:0] pc;
    logic [iw-1:0]         instr0, instr1;
    logic [addr_width-1:0] pc0, pc1;
    logic [1:0]            level;
    logic                  push, pop;
    logic [iw-1:0]         new_instr;

    // Decode handshake: an entry transfers on a rising edge where dec_valid and
    // dec_ready are both high; dec_valid never depends on dec_ready, and the head
    // entry holds steady until it transfers. A branch cancels the transfer.
    assign pop       = dec_valid & dec_ready & ~branch_taken;
    assign push      = fetch_en & ~branch_taken & ((level != 2'd2) | pop);
    assign new_instr = {mem_data_high, mem_data_low};

    assign mem_address = pc;
    assign fetch_level = level;
    assign dec_valid   = (level != 2'd0);
    assign dec_instr   = dec_valid ? instr0 : '0;
    assign dec_pc      = dec_valid ? pc0 : '0;

    // Slot 0 is always the head; slot 1 shifts down when the head retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= reset_pc;
            level  <= 2'd0;
            instr0 <= '0;
            instr1 <= '0;
            pc0    <= '0;
            pc1    <= '0;
        end else if (branch_taken) begin
            pc     <= branch_target;
            level  <= 2'd0;
            instr0 <= '0;
            instr1 <= '0;
            pc0    <= '0;
            pc1    <= '0;
        end else begin
            if (push) begin
                pc <= pc + addr_width'(2);
            end
            case ({push, pop})
                2'b10: begin
                    if (level == 2'd0) begin
                        instr0 <= new_instr;
                        pc0    <= pc;
                    end else begin
                        instr1 <= new_instr;
                        pc1    <= pc;
                    end
                    level <= level + 2'd1;
                end
                2'b01: begin
                    instr0 <= instr1;
                    pc0    <= pc1;
                    instr1 <= '0;
                    pc1    <= '0;
                    level  <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        instr0 <= new_instr;
                        pc0    <= pc;
                    end else begin
                        instr0 <= instr1;
                        pc0    <= pc1;
                        instr1 <= new_instr;
                        pc1    <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against a queue-based model of the
// fetch buffer and a byte-array memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_high;
    logic [7:0]  mem_data_low;
    logic        fetch_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        dec_ready;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [1:0]  fetch_level;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_q[$];
    logic [15:0] exp_pc_q[$];
    logic [15:0] m_pc;
    int          total;
    int          bad;

    fetch_stage #(.data_width(8), .addr_width(16), .reset_pc(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address),
        .mem_data_high(mem_data_high), .mem_data_low(mem_data_low),
        .fetch_en(fetch_en), .branch_taken(branch_taken),
        .branch_target(branch_target), .dec_ready(dec_ready),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .fetch_level(fetch_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_high = mem[mem_address];
    assign mem_data_low  = mem[16'(mem_address + 16'd1)];

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void check_outputs(string tag);
        logic [15:0] ei, ep;
        ei = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
        ep = (exp_pc_q.size() != 0) ? exp_pc_q[0] : 16'h0000;
        chk({tag, "_valid"}, 32'(dec_valid), 32'(exp_q.size() != 0));
        chk({tag, "_level"}, 32'(fetch_level), 32'(exp_q.size()));
        chk({tag, "_instr"}, 32'(dec_instr), 32'(ei));
        chk({tag, "_pc"}, 32'(dec_pc), 32'(ep));
        chk({tag, "_addr"}, 32'(mem_address), 32'(m_pc));
    endfunction

    // Reference: one clock of the fetch buffer expressed as queue operations.
    function automatic void model_step(logic en, logic br, logic [15:0] tgt, logic rdy);
        bit do_pop, do_push;
        if (br) begin
            exp_q.delete();
            exp_pc_q.delete();
            m_pc = tgt;
        end else begin
            do_pop  = (exp_q.size() != 0) && rdy;
            do_push = en && ((exp_q.size() < 2) || do_pop);
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back({mem[m_pc], mem[16'(m_pc + 16'd1)]});
                exp_pc_q.push_back(m_pc);
                m_pc = m_pc + 16'd2;
            end
        end
    endfunction

    task automatic cycle(input logic en, input logic br, input logic [15:0] tgt,
                         input logic rdy, input string tag);
        fetch_en      = en;
        branch_taken  = br;
        branch_target = tgt;
        dec_ready     = rdy;
        #1;
        check_outputs(tag);
        model_step(en, br, tgt, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
        mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
        rst_n         = 1'b0;
        fetch_en      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        dec_ready     = 1'b1;
        m_pc          = 16'h0000;

        // Reset holds everything clear even with fetch_en high across edges.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_level", 32'(fetch_level), 32'd0);
        chk("rst_instr", 32'(dec_instr), 32'd0);
        chk("rst_pc", 32'(dec_pc), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // In-order stream with one-cycle latency.
        cycle(1, 0, 16'h0, 1, "stream0");
        chk("stream_i0", 32'(dec_instr), 32'h1234);
        chk("stream_p0", 32'(dec_pc), 32'h0000);
        cycle(1, 0, 16'h0, 1, "stream1");
        chk("stream_i1", 32'(dec_instr), 32'h5678);
        chk("stream_p1", 32'(dec_pc), 32'h0002);
        cycle(1, 0, 16'h0, 1, "stream2");
        chk("stream_i2", 32'(dec_instr), 32'h9ABC);
        chk("stream_p2", 32'(dec_pc), 32'h0004);

        // Backpressure: fill to two entries, then pc and head must hold.
        cycle(0, 1, 16'h0000, 1, "bp_redir");
        for (int i = 0; i < 4; i++) cycle(1, 0, 16'h0, 0, "bp_stall");
        chk("bp_level", 32'(fetch_level), 32'd2);
        chk("bp_addr", 32'(mem_address), 32'h0004);
        chk("bp_head", 32'(dec_instr), 32'h1234);
        cycle(1, 0, 16'h0, 1, "bp_drain0");
        chk("bp_drain_i1", 32'(dec_instr), 32'h5678);
        cycle(1, 0, 16'h0, 1, "bp_drain1");
        chk("bp_drain_i2", 32'(dec_instr), 32'h9ABC);

        // Redirect while full.
        chk("br_full", 32'(fetch_level), 32'd2);
        cycle(1, 1, 16'h0100, 0, "br");
        chk("br_valid", 32'(dec_valid), 32'd0);
        chk("br_addr", 32'(mem_address), 32'h0100);
        cycle(1, 0, 16'h0, 1, "br_next");
        chk("br_pc", 32'(dec_pc), 32'h0100);

        // Wrap of pc past the top of the address space.
        cycle(0, 1, 16'hFFFE, 1, "wrap_br");
        cycle(1, 0, 16'h0, 1, "wrap0");
        chk("wrap_pc0", 32'(dec_pc), 32'hFFFE);
        cycle(1, 0, 16'h0, 1, "wrap1");
        chk("wrap_pc1", 32'(dec_pc), 32'h0000);

        // Asynchronous reset between edges with one entry buffered.
        chk("arst_pre_level", 32'(fetch_level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dec_valid), 32'd0);
        chk("arst_level", 32'(fetch_level), 32'd0);
        chk("arst_addr", 32'(mem_address), 32'h0000);
        chk("arst_instr", 32'(dec_instr), 32'd0);
        exp_q.delete();
        exp_pc_q.delete();
        m_pc = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 16'h0, 1, "resume");
        chk("resume_pc", 32'(dec_pc), 32'h0000);
        chk("resume_instr", 32'(dec_instr), 32'h1234);

        // Fetch disabled on an empty buffer: nothing moves.
        cycle(0, 1, 16'h0040, 1, "idle_br");
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 16'h0, 1, "idle");
            chk("idle_addr", 32'(mem_address), 32'h0040);
            chk("idle_valid", 32'(dec_valid), 32'd0);
        end

        // Random traffic, including odd branch targets.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  16'($urandom), 1'($urandom_range(0, 2) != 0), "rand");
        end
        #1;
        check_outputs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
